// File: rtl/width_12to8.sv
// Unpacks a stream of 12-bit words into MSB-first bytes using a nibble-granular
// shift buffer; a flush pads a lone trailing nibble out to a full byte.
module width_12to8 #(
  parameter int         CAP_NIB = 8,
  parameter logic [3:0] PAD     = 4'h0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [11:0]                      data_in,
  input  logic                             flush,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [7:0]                       data_out,
  output logic [$clog2(CAP_NIB+1)-1:0]     level
);

  localparam int CW = $clog2(CAP_NIB + 1);
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] TWO   = CW'(2);
  localparam logic [CW-1:0] THREE = CW'(3);
  localparam logic [CW-1:0] RDY_MAX = CW'(CAP_NIB - 3);

  logic [3:0]    nib_q [CAP_NIB];
  logic [3:0]    nib_d [CAP_NIB];
  logic [CW-1:0] cnt_q, cnt_d;
  logic          flushPend_q, flushPend_d;

  logic fullByte;
  logic padByte;
  logic push;
  logic pop;

  assign fullByte  = (cnt_q >= TWO);
  assign padByte   = flushPend_q && (cnt_q == ONE);
  assign ready_in  = (cnt_q <= RDY_MAX) && !flushPend_q;
  assign valid_out = fullByte || padByte;
  assign data_out  = (padByte && !fullByte) ? {nib_q[0], PAD} : {nib_q[0], nib_q[1]};
  assign level     = cnt_q;

  assign push = valid_in && ready_in;
  assign pop  = valid_out && ready_out;

  // Pop first so the incoming word lands directly behind whatever survives the pop.
  always_comb begin
    nib_d       = nib_q;
    cnt_d       = cnt_q;
    flushPend_d = flushPend_q;

    if (pop) begin
      if (fullByte) begin
        for (int i = 0; i < CAP_NIB - 2; i++) nib_d[i] = nib_q[i+2];
        nib_d[CAP_NIB-2] = 4'h0;
        nib_d[CAP_NIB-1] = 4'h0;
        cnt_d = cnt_q - TWO;
      end else begin
        cnt_d       = '0;
        flushPend_d = 1'b0;
      end
    end

    if (push) begin
      for (int i = 0; i < CAP_NIB; i++) begin
        if (i == int'(cnt_d))          nib_d[i] = data_in[11:8];
        else if (i == int'(cnt_d) + 1) nib_d[i] = data_in[7:4];
        else if (i == int'(cnt_d) + 2) nib_d[i] = data_in[3:0];
      end
      cnt_d = cnt_d + THREE;
    end

    if (flush && cnt_d[0]) flushPend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < CAP_NIB; i++) nib_q[i] <= 4'h0;
      cnt_q       <= '0;
      flushPend_q <= 1'b0;
    end else begin
      for (int i = 0; i < CAP_NIB; i++) nib_q[i] <= nib_d[i];
      cnt_q       <= cnt_d;
      flushPend_q <= flushPend_d;
    end
  end

endmodule

// File: tb/tb_width_12to8.sv
// Directed bench for width_12to8: default 8-nibble instance plus a 4-nibble
// instance for the minimum-capacity boundary.
module tb_width_12to8;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic        ready_in;
  logic [11:0] data_in;
  logic        flush;
  logic        valid_out;
  logic        ready_out;
  logic [7:0]  data_out;
  logic [3:0]  level;

  logic        c4ValidIn;
  logic        c4ReadyIn;
  logic [11:0] c4DataIn;
  logic        c4Flush;
  logic        c4ValidOut;
  logic        c4ReadyOut;
  logic [7:0]  c4DataOut;
  logic [2:0]  c4Level;

  int checks   = 0;
  int failures = 0;

  logic [11:0] wordsQ[$];
  logic [7:0]  gotQ[$];
  int          maxLevel;
  int          bubbles;

  always #5 clk = ~clk;

  width_12to8 #(.CAP_NIB(8), .PAD(4'h0)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .ready_in(ready_in),
    .data_in(data_in), .flush(flush), .valid_out(valid_out),
    .ready_out(ready_out), .data_out(data_out), .level(level)
  );

  width_12to8 #(.CAP_NIB(4), .PAD(4'h0)) dut4 (
    .clk(clk), .rst(rst), .valid_in(c4ValidIn), .ready_in(c4ReadyIn),
    .data_in(c4DataIn), .flush(c4Flush), .valid_out(c4ValidOut),
    .ready_out(c4ReadyOut), .data_out(c4DataOut), .level(c4Level)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feeds wordsQ and records every popped byte into gotQ for a fixed cycle budget.
  task automatic drive_and_collect(input int maxCycles);
    logic       doPush;
    logic       doPop;
    logic [7:0] b;
    for (int c = 0; c < maxCycles; c++) begin
      valid_in = (wordsQ.size() > 0);
      data_in  = (wordsQ.size() > 0) ? wordsQ[0] : 12'h000;
      #0;
      if (int'(level) > maxLevel) maxLevel = int'(level);
      if (level >= 4'd2 && !valid_out) bubbles++;
      doPush = valid_in && ready_in;
      doPop  = valid_out && ready_out;
      b      = data_out;
      step();
      if (doPush) void'(wordsQ.pop_front());
      if (doPop) gotQ.push_back(b);
    end
    valid_in = 1'b0;
    data_in  = 12'h000;
  endtask

  task automatic test_reset();
    ready_out = 1'b0;
    valid_in  = 1'b1;
    data_in   = 12'h777;
    step();
    step();
    valid_in = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid_out got=%b exp=0", valid_out); end
    checks++; if (ready_in !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready_in got=%b exp=1", ready_in); end
    checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL reset_level got=%0d exp=0", level); end
    checks++; if (data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_data_out got=%h exp=00", data_out); end
    ready_out = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (valid_out !== 1'b0) begin failures++; $display("[TB] FAIL reset_no_stale got=%b exp=0", valid_out); end
    end
    ready_out = 1'b0;
  endtask

  task automatic test_basic();
    logic [7:0] exp[3] = '{8'hAB, 8'hCD, 8'hEF};
    gotQ.delete();
    wordsQ = '{12'hABC, 12'hDEF};
    ready_out = 1'b1;
    drive_and_collect(10);
    checks++; if (gotQ.size() != 3) begin failures++; $display("[TB] FAIL basic_count got=%0d exp=3", gotQ.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < gotQ.size()) begin
        checks++; if (gotQ[i] !== exp[i]) begin failures++; $display("[TB] FAIL basic_byte%0d got=%h exp=%h", i, gotQ[i], exp[i]); end
      end
    end
    checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL basic_level got=%0d exp=0", level); end
    ready_out = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [7:0] exp[3] = '{8'h12, 8'h34, 8'h56};
    gotQ.delete();
    wordsQ = '{12'h123, 12'h456};
    ready_out = 1'b0;
    drive_and_collect(4);
    checks++; if (level !== 4'd6) begin failures++; $display("[TB] FAIL bp_level got=%0d exp=6", level); end
    checks++; if (ready_in !== 1'b0) begin failures++; $display("[TB] FAIL bp_ready_in got=%b exp=0", ready_in); end
    for (int i = 0; i < 2; i++) begin
      checks++; if (valid_out !== 1'b1 || data_out !== 8'h12) begin failures++; $display("[TB] FAIL bp_hold v=%b d=%h exp v=1 d=12", valid_out, data_out); end
      step();
    end
    ready_out = 1'b1;
    drive_and_collect(6);
    checks++; if (gotQ.size() != 3) begin failures++; $display("[TB] FAIL bp_count got=%0d exp=3", gotQ.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < gotQ.size()) begin
        checks++; if (gotQ[i] !== exp[i]) begin failures++; $display("[TB] FAIL bp_byte%0d got=%h exp=%h", i, gotQ[i], exp[i]); end
      end
    end
    checks++; if (level !== 4'd0) begin failures++; $display("[TB] FAIL bp_drained got=%0d exp=0", level); end
    ready_out = 1'b0;
  endtask

  task automatic test_flush();
    logic [7:0] b;
    wordsQ = '{12'h9A5};
    ready_out = 1'b0;
    drive_and_collect(2);
    b = data_out;
    ready_out = 1'b1;
    step();
    ready_out = 1'b0;
    checks++; if (b !== 8'h9A) begin failures++; $display("[TB] FAIL flush_first got=%h exp=9a", b); end
    checks++; if (level !== 4'd1 || valid_out !== 1'b0) begin failures++; $display("[TB] FAIL flush_residue lvl=%0d v=%b exp lvl=1 v=0", level, valid_out); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++; if (valid_out !== 1'b1 || data_out !== 8'h50) begin failures++; $display("[TB] FAIL flush_pad v=%b d=%h exp v=1 d=50", valid_out, data_out); end
      checks++; if (ready_in !== 1'b0) begin failures++; $display("[TB] FAIL flush_ready_in got=%b exp=0", ready_in); end
      step();
    end
    ready_out = 1'b1;
    step();
    ready_out = 1'b0;
    checks++; if (level !== 4'd0 || valid_out !== 1'b0 || ready_in !== 1'b1) begin failures++; $display("[TB] FAIL flush_done lvl=%0d v=%b r=%b exp lvl=0 v=0 r=1", level, valid_out, ready_in); end
  endtask

  task automatic test_concurrent();
    logic [7:0] exp[9] = '{8'h00, 8'h10, 8'h02, 8'h00, 8'h30, 8'h04, 8'h00, 8'h50, 8'h06};
    gotQ.delete();
    wordsQ = '{12'h001, 12'h002, 12'h003, 12'h004, 12'h005, 12'h006};
    maxLevel = 0;
    bubbles  = 0;
    ready_out = 1'b1;
    drive_and_collect(20);
    checks++; if (gotQ.size() != 9) begin failures++; $display("[TB] FAIL conc_count got=%0d exp=9", gotQ.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < gotQ.size()) begin
        checks++; if (gotQ[i] !== exp[i]) begin failures++; $display("[TB] FAIL conc_byte%0d got=%h exp=%h", i, gotQ[i], exp[i]); end
      end
    end
    checks++; if (maxLevel > 8) begin failures++; $display("[TB] FAIL conc_max_level got=%0d exp<=8", maxLevel); end
    checks++; if (bubbles != 0) begin failures++; $display("[TB] FAIL conc_bubbles got=%0d exp=0", bubbles); end
    ready_out = 1'b0;
  endtask

  task automatic test_even_flush();
    logic [7:0] exp[3] = '{8'hAB, 8'hCD, 8'hEF};
    gotQ.delete();
    wordsQ = '{12'hABC, 12'hDEF};
    ready_out = 1'b0;
    drive_and_collect(3);
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (level !== 4'd6 || ready_in !== 1'b0) begin failures++; $display("[TB] FAIL even_flush_level lvl=%0d r=%b exp lvl=6 r=0", level, ready_in); end
    ready_out = 1'b1;
    drive_and_collect(8);
    checks++; if (gotQ.size() != 3) begin failures++; $display("[TB] FAIL even_count got=%0d exp=3", gotQ.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < gotQ.size()) begin
        checks++; if (gotQ[i] !== exp[i]) begin failures++; $display("[TB] FAIL even_byte%0d got=%h exp=%h", i, gotQ[i], exp[i]); end
      end
    end
    checks++; if (ready_in !== 1'b1) begin failures++; $display("[TB] FAIL even_ready_after got=%b exp=1", ready_in); end
    ready_out = 1'b0;
  endtask

  task automatic test_cap4();
    c4ValidIn = 1'b1;
    c4DataIn  = 12'h3C7;
    step();
    c4ValidIn = 1'b0;
    checks++; if (c4Level !== 3'd3 || c4ReadyIn !== 1'b0) begin failures++; $display("[TB] FAIL cap4_full lvl=%0d r=%b exp lvl=3 r=0", c4Level, c4ReadyIn); end
    checks++; if (c4ValidOut !== 1'b1 || c4DataOut !== 8'h3C) begin failures++; $display("[TB] FAIL cap4_byte0 v=%b d=%h exp v=1 d=3c", c4ValidOut, c4DataOut); end
    c4ValidIn = 1'b1;
    c4DataIn  = 12'h8E1;
    step();
    checks++; if (c4Level !== 3'd3 || c4ReadyIn !== 1'b0) begin failures++; $display("[TB] FAIL cap4_hold lvl=%0d r=%b exp lvl=3 r=0", c4Level, c4ReadyIn); end
    c4ValidIn  = 1'b0;
    c4ReadyOut = 1'b1;
    step();
    c4ReadyOut = 1'b0;
    checks++; if (c4Level !== 3'd1 || c4ReadyIn !== 1'b1) begin failures++; $display("[TB] FAIL cap4_after_pop lvl=%0d r=%b exp lvl=1 r=1", c4Level, c4ReadyIn); end
    c4ValidIn = 1'b1;
    step();
    c4ValidIn = 1'b0;
    checks++; if (c4Level !== 3'd4 || c4DataOut !== 8'h78) begin failures++; $display("[TB] FAIL cap4_refill lvl=%0d d=%h exp lvl=4 d=78", c4Level, c4DataOut); end
  endtask

  initial begin
    rst        = 1'b1;
    valid_in   = 1'b0;
    data_in    = 12'h000;
    flush      = 1'b0;
    ready_out  = 1'b0;
    c4ValidIn  = 1'b0;
    c4DataIn   = 12'h000;
    c4Flush    = 1'b0;
    c4ReadyOut = 1'b0;
    maxLevel   = 0;
    bubbles    = 0;
    step();
    step();
    rst = 1'b0;
    step();
    test_reset();
    test_basic();
    test_backpressure();
    test_flush();
    test_concurrent();
    test_even_flush();
    test_cap4();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/width_12to8.md
Name: width_12to8

Overview:
- Downstream counterpart of the 8-to-12 packer: consumes the packed 12-bit word stream and restores the original 8-bit byte stream, MSB-first.
- Uses a nibble-granular elastic buffer, since every 2 words carry exactly 3 bytes.
- Sits on the receive side of the link, ahead of byte-oriented consumers.
- Has valid/ready on both sides and supports a flush to drain a trailing half byte.

Parameters:
- CAP_NIB, 8: buffer capacity in 4-bit nibbles. Legal range is 4..16.
- PAD, 4'h0: nibble value appended below a lone residual nibble on flush.

Ports:
- clk, input, 1: single clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- valid_in, input, 1: data_in holds a valid 12-bit word.
- ready_in, output, 1: block can accept a word this cycle.
- data_in, input, 12: packed word; bits [11:8] form the oldest nibble.
- flush, input, 1: single-cycle pulse marking end of stream; pads a residual nibble into a byte.
- valid_out, output, 1: data_out holds a valid byte.
- ready_out, input, 1: downstream accepts the byte this cycle.
- data_out, output, 8: restored byte.
- level, output, $clog2(CAP_NIB+1): current nibble count, for debug and status.

Behaviour:
- Storage:
  - nib[0..CAP_NIB-1] is a 4-bit register array with nib[0] as the head.
  - cnt is the number of valid nibbles, 0..CAP_NIB.
- Reset (rst=1 at a clock edge):
  - cnt=0, all nib=0, flush_pend=0.
  - Outputs: valid_out=0, data_out=8'h00, ready_in=1, level=0.
  - Reset mid-stream discards all buffered nibbles; no byte is emitted afterwards from pre-reset data.
- ready_in:
  - Equals (cnt <= CAP_NIB-3), decoded from registers only.
  - Does not depend on valid_in or ready_out, so there is no combinational path.
- valid_out:
  - Equals (cnt >= 2) OR (flush_pend AND cnt == 1), decoded from registers.
- data_out:
  - When cnt >= 2: {nib[0], nib[1]}.
  - When the flush case applies: {nib[0], PAD}.
  - When valid_out=0: data_out = {nib[0], nib[1]} and is don't-care; the bench must not check it.
- Handshakes:
  - push = valid_in & ready_in.
  - pop = valid_out & ready_out.
  - A producer must hold data_in stable while valid_in=1 and ready_in=0.
  - valid_out, once asserted, stays asserted with stable data_out until popped (guaranteed by construction).
- Update each cycle, with pops shifting the head and pushes appending at the tail:
  - pop of a full byte: nibbles shift by 2; cnt -= 2.
  - pop in the flush case: cnt -> 0 and flush_pend clears.
  - push: data_in[11:8], [7:4], [3:0] written at post-pop positions cnt', cnt'+1, cnt'+2; cnt' += 3.
  - Simultaneous push and byte-pop: net cnt += 1, in a single cycle.
- Latency:
  - A word pushed at edge N makes its first byte visible (valid_out=1) after edge N when cnt >= 2 after that edge. There is no additional pipeline stage.
  - Steady-state throughput: output may pop 1 byte per cycle; input accepts at most 1 word per cycle, limited by ready_in.
- Flush:
  - flush=1 sets flush_pend if cnt is odd after the same-cycle update.
  - flush_pend clears on the padded pop or on rst.
  - flush with even cnt has no effect.
  - While flush_pend=1, ready_in is forced to 0 so the padded byte cannot be merged with new data.
- Boundaries:
  - cnt=CAP_NIB-2 or higher: ready_in=0.
  - cnt=0 or 1 (no flush): valid_out=0.
  - cnt never exceeds CAP_NIB and never underflows.
  - With CAP_NIB=4, the sequence is: one word pushed, ready_in=0 until one byte has been popped.

Test Plan:
1. Reset: assert rst for 2 cycles mid-traffic -> next cycle valid_out=0, ready_in=1, level=0, data_out=8'h00.
2. Basic unpack: push 12'hABC then 12'hDEF with ready_out=1 -> bytes 8'hAB, 8'hCD, 8'hEF in order. level returns to 0 and no extra byte is emitted.
3. Backpressure: hold ready_out=0 and push 12'h123, 12'h456 (CAP_NIB=8) -> ready_in drops after the 2nd word (level=6). data_out holds 8'h12 stable. Release -> 8'h12, 8'h34, 8'h56.
4. Flush residue: push 12'h9A5, pop 8'h9A, pulse flush -> valid_out=1 with data_out=8'h50 (PAD=0), then level=0. ready_in=0 while the pad is pending.
5. Concurrent push/pop: continuous valid_in=1 and ready_out=1 over 6 words 12'h001..12'h006 -> 9 bytes 00,10,02,00,30,04,00,50,06. No bubble while level>=2, and level never exceeds 8.
6. Flush with even count: push 12'hABC and 12'hDEF, pulse flush before any pop -> no padded byte; output is exactly AB, CD, EF.
